da_fir_sequencer: RTL and testbench

//  Control and configuration sequencer for the 4-tap bit-serial distributed-arithmetic FIR datapath.
//  - Replaces the free-running byte clock with explicit strobes and a valid/ready sample handshake.
//  - Steps the bit index and drives the 4-bit coefficient bit-slice (wkl) that addresses the partial-sum mux.
//  - Owns a double-buffered coefficient bank that software can rewrite without corrupting a sample in flight.

---
 rtl/da_fir_sequencer.sv | 119 +++++++++++
 tb/tb_da_fir_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/da_fir_sequencer.sv
// Control and configuration sequencer for a 4-tap bit-serial distributed-arithmetic FIR.
// Generates per-bit strobes, the coefficient bit-slice (wkl) and owns a double-buffered coefficient bank.
//
//  state | meaning
//  ------+---------------------------------------------------
//  IDLE  | no sample in flight, ready to accept
//  SHIFT | stepping bit index 0..CW-1 through the datapath
//  DONE  | result register valid, waiting for the consumer
module da_fir_sequencer #(
    parameter int CW = 8,
    parameter int CNTW = 3,
    parameter logic [CW-1:0] COEF0 = 8'hF1,
    parameter logic [CW-1:0] COEF1 = 8'hF6,
    parameter logic [CW-1:0] COEF2 = 8'h09,
    parameter logic [CW-1:0] COEF3 = 8'h05
) (
    input  logic            clk_bit,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            load_x,
    output logic [CNTW-1:0] count,
    output logic [3:0]      wkl,
    output logic            acc_clr,
    output logic            acc_sub,
    output logic            sum_latch,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [CW-1:0]   cfg_data,
    input  logic            cfg_commit,
    output logic            cfg_pending,
    output logic            busy
);

    localparam logic [CNTW-1:0] LAST = CNTW'(CW - 1);
    localparam logic [3:0][CW-1:0] COEF_RST = {COEF3, COEF2, COEF1, COEF0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [CNTW-1:0] count_q;
    logic first_done;
    logic pending;
    logic apply;
    logic at_last;
    logic [3:0][CW-1:0] shadow, shadow_fwd, active;

    assign at_last = (state == SHIFT) && (count_q == LAST);

    always_ff @(posedge clk_bit) begin
        if (rst) begin
            state      <= IDLE;
            count_q    <= '0;
            first_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            count_q    <= (state == SHIFT && !at_last) ? count_q + 1'b1 : '0;
            first_done <= at_last;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_x) state_nxt = SHIFT;
            SHIFT:   if (at_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        load_x    = in_valid && in_ready;
        busy      = (state == SHIFT);
        out_valid = (state == DONE);
        sum_latch = (state == DONE) && first_done;
        acc_clr   = (state == SHIFT) && (count_q == '0);
        acc_sub   = at_last;
        count     = count_q;
        wkl       = '0;
        if (state == SHIFT) begin
            for (int k = 0; k < 4; k++) wkl[k] = active[k][count_q];
        end
    end

    // A write in the same cycle as the copy is forwarded so it lands in active too.
    always_comb begin
        shadow_fwd = shadow;
        if (cfg_we) shadow_fwd[cfg_addr] = cfg_data;
    end

    // Copy only outside SHIFT so a sample never sees its coefficients change mid-flight.
    assign apply = (pending || cfg_commit) && (state != SHIFT);
    assign cfg_pending = pending;

    always_ff @(posedge clk_bit) begin
        if (rst) begin
            shadow  <= COEF_RST;
            active  <= COEF_RST;
            pending <= 1'b0;
        end else begin
            shadow <= shadow_fwd;
            if (apply) begin
                active  <= shadow_fwd;
                pending <= 1'b0;
            end else if (cfg_commit) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_da_fir_sequencer.sv
// Directed self-checking bench for da_fir_sequencer: handshake timing, strobes,
// wkl bit-slices, coefficient double-buffering and mid-sample reset.
module tb_da_fir_sequencer;

    logic       clk_bit = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       load_x;
    logic [2:0] count;
    logic [3:0] wkl;
    logic       acc_clr;
    logic       acc_sub;
    logic       sum_latch;
    logic       out_valid;
    logic       out_ready;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_commit;
    logic       cfg_pending;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Expected active coefficients, maintained by hand alongside the stimulus.
    logic [7:0] c0, c1, c2, c3;

    da_fir_sequencer dut (
        .clk_bit(clk_bit), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .load_x(load_x), .count(count), .wkl(wkl), .acc_clr(acc_clr), .acc_sub(acc_sub),
        .sum_latch(sum_latch), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .busy(busy)
    );

    always #5 clk_bit = ~clk_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_bit);
        #1;
    endtask

    function automatic logic [3:0] exp_wkl(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input int b);
        return {a3[b], a2[b], a1[b], a0[b]};
    endfunction

    task automatic wait_idle();
        for (int n = 0; n < 20 && (busy || out_valid); n++) tick();
        check("idle_reached", {30'd0, busy, out_valid}, 32'd0);
    endtask

    // Accept one sample from IDLE; returns in SHIFT cycle with count 0.
    task automatic accept_one();
        in_valid = 1'b1;
        #1;
        check("accept_load_x", load_x, 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 0;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
        c0 = 8'hF1; c1 = 8'hF6; c2 = 8'h09; c3 = 8'h05;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state and idle hold
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_wkl", wkl, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_strobes", {acc_clr, acc_sub, sum_latch, load_x}, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", {busy, out_valid, in_ready, count}, {1'b0, 1'b0, 1'b1, 3'd0});
        end

        // Single sample, default coefficients
        out_ready = 1'b1;
        accept_one();
        for (int i = 0; i < 8; i++) begin
            check("s1_count", count, i);
            check("s1_wkl", wkl, exp_wkl(c0, c1, c2, c3, i));
            check("s1_strobe", {acc_clr, acc_sub, sum_latch, out_valid},
                  {i == 0, i == 7, 1'b0, 1'b0});
            tick();
        end
        check("s1_wkl_c0", 4'b1101, exp_wkl(c0, c1, c2, c3, 0));
        check("s1_done", {sum_latch, out_valid, in_ready, busy, wkl}, {4'b1110, 4'b0000});
        tick();
        check("s1_idle", {sum_latch, out_valid, in_ready}, 3'b001);

        // Back-to-back stream: one accept every 9 cycles
        in_valid = 1'b1;
        #1;
        check("b2b_first", load_x, 1);
        for (int c = 1; c <= 27; c++) begin
            tick();
            check("b2b_load_x", load_x, (c % 9) == 0);
            check("b2b_sum_latch", sum_latch, (c % 9) == 0);
        end
        tick();
        in_valid = 1'b0;
        wait_idle();

        // Backpressure in DONE
        out_ready = 1'b0;
        accept_one();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int j = 0; j < 5; j++) begin
            check("bp_hold", {out_valid, in_ready, load_x, sum_latch}, {1'b1, 1'b0, 1'b0, j == 0});
            if (j < 4) tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", {in_ready, load_x, sum_latch}, 3'b110);
        tick();
        check("bp_restart", {busy, count}, {1'b1, 3'd0});
        in_valid = 1'b0;
        wait_idle();

        // Commit mid-sample: current sample unchanged, next sample (accepted at the copy edge) updated
        accept_one();
        tick(); tick(); tick();
        check("cm_count3", count, 3);
        cfg_we = 1; cfg_addr = 2'd0; cfg_data = 8'h01; cfg_commit = 1;
        tick();
        cfg_we = 0; cfg_commit = 0;
        for (int i = 4; i < 8; i++) begin
            check("cm_old_wkl", wkl, exp_wkl(c0, c1, c2, c3, i));
            check("cm_pending", cfg_pending, 1);
            tick();
        end
        check("cm_done_pending", {sum_latch, cfg_pending}, 2'b11);
        in_valid = 1'b1;
        #1;
        check("cm_b2b_load", load_x, 1);
        tick();
        in_valid = 1'b0;
        c0 = 8'h01;
        check("cm_cleared", cfg_pending, 0);
        for (int i = 0; i < 8; i++) begin
            check("cm_new_wkl", wkl, exp_wkl(c0, c1, c2, c3, i));
            check("cm_tap0_bit", wkl[0], i == 0);
            tick();
        end
        wait_idle();

        // Write + commit in the same IDLE cycle: forwarded and applied immediately
        cfg_we = 1; cfg_addr = 2'd1; cfg_data = 8'h80; cfg_commit = 1;
        tick();
        cfg_we = 0; cfg_commit = 0;
        c1 = 8'h80;
        check("fw_pending", cfg_pending, 0);
        accept_one();
        for (int i = 0; i < 5; i++) begin
            check("fw_wkl", wkl, exp_wkl(c0, c1, c2, c3, i));
            tick();
        end

        // Reset at count 5 aborts the sample and restores coefficients
        check("rs_count5", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c0 = 8'hF1; c1 = 8'hF6;
        check("rs_idle", {busy, count, sum_latch, out_valid, in_ready}, {1'b0, 3'd0, 3'b001});
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rs_no_latch", {sum_latch, out_valid}, 2'b00);
        end
        accept_one();
        for (int i = 0; i < 8; i++) begin
            check("rs_def_wkl", wkl, exp_wkl(c0, c1, c2, c3, i));
            tick();
        end
        check("rs_c7_wkl", wkl, 0);
        check("rs_done", sum_latch, 1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
